// File: rtl/fwd_pkg.sv
// ============================================================================
//  Module      : fwd_pkg
//  Description : Shared types and helpers for the EX-stage forwarding and
//                load-use hazard unit (slot record, select width, RF code).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

    // Slot fields are sized for the widest supported configuration; narrower
    // register addresses and ready stages are zero-extended into them.
    localparam int FWD_MAX_AW    = 8;
    localparam int FWD_MAX_SEL_W = 8;

    // Forward-select code meaning "take the operand from the register file".
    localparam int FWD_SEL_RF    = 0;

    // One in-flight producer: valid, destination, writes-rd, first ready slot.
    typedef struct packed {
        logic                     valid;
        logic [FWD_MAX_AW-1:0]    rd;
        logic                     wr;
        logic [FWD_MAX_SEL_W-1:0] rdy;
    } fwd_slot_t;

    // Width of a forward select able to encode 0 (regfile) .. num_fwd (taps).
    function automatic int fwd_sel_width(input int num_fwd);
        return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_unit_src_match.sv
// ============================================================================
//  Module      : fwd_src_match
//  Description : Priority matcher for one source operand. Searches the
//                forwardable slots and reports the youngest producer of the
//                operand plus whether its result is not yet available.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5,
    localparam int FWD_SEL_W = fwd_sel_width(NUM_FWD)
) (
    input  fwd_slot_t            i_slots [NUM_FWD],
    input  logic [REG_AW-1:0]    i_rs,
    input  logic                 i_rs_used,
    output logic                 o_hit,
    output logic [FWD_SEL_W-1:0] o_j,
    output logic                 o_needs_stall
);

    // Scan oldest to youngest so the lowest matching index is the final winner.
    always_comb begin
        o_hit         = 1'b0;
        o_j           = '0;
        o_needs_stall = 1'b0;
        if (i_rs_used && (i_rs != '0)) begin
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (i_slots[j].valid && i_slots[j].wr &&
                    (i_slots[j].rd == FWD_MAX_AW'(i_rs)) && (i_slots[j].rd != '0)) begin
                    o_hit         = 1'b1;
                    o_j           = FWD_SEL_W'(j);
                    o_needs_stall = (i_slots[j].rdy > FWD_MAX_SEL_W'(j + 1));
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : EX-stage forwarding and load-use hazard unit. Tracks the
//                in-flight producers in a shadow pipeline (EX + NUM_FWD taps),
//                raises a combinational ID stall when a needed result is not
//                ready, and registers per-operand forward selects for EX.
//  Options     : FWD_PERF_CNT_EN - adds a saturating stall_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5,
    localparam int FWD_SEL_W = fwd_sel_width(NUM_FWD)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]           id_rs_used,
    input  logic [REG_AW-1:0]            id_rd,
    input  logic                         id_regwrite,
    input  logic [FWD_SEL_W-1:0]         id_rdy_stage,
    input  logic                         hold,
    input  logic                         flush,
    output logic                         stall,
    output logic                         ex_valid,
    output logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    localparam logic [FWD_SEL_W-1:0] C_RDY_MIN = FWD_SEL_W'(1);
    localparam logic [FWD_SEL_W-1:0] C_RDY_MAX = FWD_SEL_W'(NUM_FWD);
    localparam logic [FWD_SEL_W-1:0] C_ONE     = FWD_SEL_W'(1);

    fwd_slot_t                    slot_q [NUM_FWD+1];
    fwd_slot_t                    slot_d [NUM_FWD+1];
    fwd_slot_t                    w_search [NUM_FWD];
    logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel_q;
    logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel_d;
    logic [FWD_SEL_W-1:0]         w_rdy_clamped;
    logic [NUM_SRC-1:0]           w_hit;
    logic [NUM_SRC-1:0]           w_needs_stall;
    logic [FWD_SEL_W-1:0]         w_j [NUM_SRC];
    logic                         w_accept;

    // Only EX and the taps before the last one can still feed a later consumer.
    always_comb begin
        for (int k = 0; k < NUM_FWD; k++) begin
            w_search[k] = slot_q[k];
        end
    end

    // Ready stage 0 is treated as ALU-like; anything past the last tap saturates.
    always_comb begin
        w_rdy_clamped = id_rdy_stage;
        if (id_rdy_stage < C_RDY_MIN) begin
            w_rdy_clamped = C_RDY_MIN;
        end else if (id_rdy_stage > C_RDY_MAX) begin
            w_rdy_clamped = C_RDY_MAX;
        end
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_match #(
            .NUM_FWD (NUM_FWD),
            .REG_AW  (REG_AW)
        ) u_match (
            .i_slots       (w_search),
            .i_rs          (id_rs[s*REG_AW +: REG_AW]),
            .i_rs_used     (id_rs_used[s]),
            .o_hit         (w_hit[s]),
            .o_j           (w_j[s]),
            .o_needs_stall (w_needs_stall[s])
        );
    end

    // A flushed ID instruction can neither stall nor enter EX.
    assign stall    = id_valid & ~flush & (|w_needs_stall);
    assign w_accept = id_valid & ~flush & ~(|w_needs_stall);

    // Shift the shadow pipeline and compute EX-aligned selects on each advance.
    always_comb begin
        slot_d    = slot_q;
        fwd_sel_d = fwd_sel_q;
        if (!hold) begin
            for (int k = NUM_FWD; k >= 1; k--) begin
                slot_d[k] = slot_q[k-1];
            end
            slot_d[0] = '0;
            fwd_sel_d = '0;
            if (w_accept) begin
                slot_d[0].valid = 1'b1;
                slot_d[0].rd    = FWD_MAX_AW'(id_rd);
                slot_d[0].wr    = id_regwrite;
                slot_d[0].rdy   = FWD_MAX_SEL_W'(w_rdy_clamped);
                for (int s = 0; s < NUM_SRC; s++) begin
                    fwd_sel_d[s*FWD_SEL_W +: FWD_SEL_W] =
                        w_hit[s] ? (w_j[s] + C_ONE) : FWD_SEL_W'(FWD_SEL_RF);
                end
            end
        end
    end

    // Slot and select state; reset drops every in-flight producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NUM_FWD; k++) begin
                slot_q[k] <= '0;
            end
            fwd_sel_q <= '0;
        end else begin
            slot_q    <= slot_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    assign ex_valid = slot_q[0].valid;
    assign fwd_sel  = fwd_sel_q;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Count cycles lost to hazards; frozen cycles are not charged.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Saturating stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Directed scoreboard bench for fwd_hazard_unit (defaults
//                NUM_SRC=2, NUM_FWD=2, REG_AW=5). Optional FWD_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic [1:0] id_rdy_stage;
    logic       hold;
    logic       flush;
    logic       stall;
    logic       ex_valid;
    logic [3:0] fwd_sel;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fwd_hazard_unit #(
        .NUM_SRC (2),
        .NUM_FWD (2),
        .REG_AW  (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_rdy_stage (id_rdy_stage),
        .hold         (hold),
        .flush        (flush),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .fwd_sel      (fwd_sel)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    typedef struct packed {
        logic        stall;
        logic        exv;
        logic [3:0]  fwd;
        logic        chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_cmp;
    int    n_bad;
    logic        pend_chk;
    logic [31:0] pend_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Drive one ID-cycle and queue the outputs expected during that cycle.
    task automatic row(input int v, input int r1, input int r2, input int used,
                       input int rd, input int wr, input int rdy, input int hd, input int fl,
                       input int es, input int ev, input int ef0, input int ef1, input string nm);
        exp_t e;
        @(negedge clk);
        id_valid     = 1'(v);
        id_rs        = {5'(r2), 5'(r1)};
        id_rs_used   = 2'(used);
        id_rd        = 5'(rd);
        id_regwrite  = 1'(wr);
        id_rdy_stage = 2'(rdy);
        hold         = 1'(hd);
        flush        = 1'(fl);
        e.stall   = 1'(es);
        e.exv     = 1'(ev);
        e.fwd     = {2'(ef1), 2'(ef0)};
        e.chk_cnt = pend_chk;
        e.cnt     = pend_cnt;
        pend_chk  = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int ev, input int ef0, input int ef1, input string nm);
        row(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ev, ef0, ef1, nm);
    endtask

    // Monitor: compares queued expectations against the DUT each cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, "stall",    32'(stall),    32'(e.stall));
                check(nm, "ex_valid", 32'(ex_valid), 32'(e.exv));
                check(nm, "fwd_sel",  32'(fwd_sel),  32'(e.fwd));
`ifdef FWD_PERF_CNT_EN
                if (e.chk_cnt) check(nm, "stall_cnt", stall_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_bad = 0; pend_chk = 1'b0; pend_cnt = '0;
        rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
        id_regwrite = 1'b0; id_rdy_stage = 2'd1; hold = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        idle(0, 0, 0, "rst_state");
        #3 rst_n = 1'b1;
        idle(0, 0, 0, "post_rst");

        // 1: ALU producer, immediate consumer -> tap 1
        row(1, 0, 0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 0, "t1_prod");
        row(1, 3, 0, 1,  7, 1, 1, 0, 0,  0, 1, 0, 0, "t1_cons");
        idle(1, 1, 0, "t1_fwd_mem");
        idle(0, 0, 0, "t1_drain");
        idle(0, 0, 0, "t1_drain2");

        // 2a: one unrelated instruction -> tap 2
        row(1, 0, 0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 0, "t2a_prod");
        row(1, 0, 0, 0,  9, 1, 1, 0, 0,  0, 1, 0, 0, "t2a_unrel");
        row(1, 3, 0, 1, 10, 1, 1, 0, 0,  0, 1, 0, 0, "t2a_cons");
        idle(1, 2, 0, "t2a_fwd_wb");
        idle(0, 0, 0, "t2a_drain");
        idle(0, 0, 0, "t2a_drain2");

        // 2b: two unrelated instructions -> regfile
        row(1, 0, 0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 0, "t2b_prod");
        row(1, 0, 0, 0,  9, 1, 1, 0, 0,  0, 1, 0, 0, "t2b_unrel1");
        row(1, 0, 0, 0, 11, 1, 1, 0, 0,  0, 1, 0, 0, "t2b_unrel2");
        row(1, 3, 0, 1, 10, 1, 1, 0, 0,  0, 1, 0, 0, "t2b_cons");
        idle(1, 0, 0, "t2b_fwd_rf");
        idle(0, 0, 0, "t2b_drain");
        idle(0, 0, 0, "t2b_drain2");

        // 3: load-use on src1 -> one stall, bubble, then tap 2 on src1
        row(1, 0, 0, 0,  5, 1, 2, 0, 0,  0, 0, 0, 0, "t3_load");
        row(1, 0, 5, 2, 12, 1, 1, 0, 0,  1, 1, 0, 0, "t3_stall");
        row(1, 0, 5, 2, 12, 1, 1, 0, 0,  0, 0, 0, 0, "t3_bubble");
        pend_chk = 1'b1; pend_cnt = 32'd1;
        idle(1, 0, 2, "t3_fwd");
        idle(0, 0, 0, "t3_drain");
        idle(0, 0, 0, "t3_drain2");

        // 4: two producers of x4 -> youngest (tap 1) wins
        row(1, 0, 0, 0,  4, 1, 1, 0, 0,  0, 0, 0, 0, "t4_p1");
        row(1, 0, 0, 0,  4, 1, 1, 0, 0,  0, 1, 0, 0, "t4_p2");
        row(1, 4, 0, 1, 15, 1, 1, 0, 0,  0, 1, 0, 0, "t4_cons");
        idle(1, 1, 0, "t4_youngest");
        idle(0, 0, 0, "t4_drain");
        idle(0, 0, 0, "t4_drain2");

        // 5a: x0 never matches, even for a load
        row(1, 0, 0, 0,  0, 1, 2, 0, 0,  0, 0, 0, 0, "t5a_prod_x0");
        row(1, 0, 0, 1, 16, 1, 1, 0, 0,  0, 1, 0, 0, "t5a_cons_x0");
        idle(1, 0, 0, "t5a_fwd");
        idle(0, 0, 0, "t5a_drain");
        idle(0, 0, 0, "t5a_drain2");

        // 5b: producer without regwrite never matches
        row(1, 0, 0, 0,  6, 0, 2, 0, 0,  0, 0, 0, 0, "t5b_prod_nowr");
        row(1, 6, 0, 1, 17, 1, 1, 0, 0,  0, 1, 0, 0, "t5b_cons");
        idle(1, 0, 0, "t5b_fwd");
        idle(0, 0, 0, "t5b_drain");
        idle(0, 0, 0, "t5b_drain2");

        // 5c: source not used -> no stall, regfile
        row(1, 0, 0, 0,  8, 1, 2, 0, 0,  0, 0, 0, 0, "t5c_load");
        row(1, 8, 0, 0, 18, 1, 1, 0, 0,  0, 1, 0, 0, "t5c_unused");
        idle(1, 0, 0, "t5c_fwd");
        idle(0, 0, 0, "t5c_drain");
        idle(0, 0, 0, "t5c_drain2");

        // 5d: ready stage 3 clamps to 2 -> single stall only
        row(1, 0, 0, 0,  8, 1, 3, 0, 0,  0, 0, 0, 0, "t5d_prod_r3");
        row(1, 8, 0, 1, 19, 1, 1, 0, 0,  1, 1, 0, 0, "t5d_stall");
        row(1, 8, 0, 1, 19, 1, 1, 0, 0,  0, 0, 0, 0, "t5d_bubble");
        idle(1, 2, 0, "t5d_fwd");
        idle(0, 0, 0, "t5d_drain");
        idle(0, 0, 0, "t5d_drain2");

        // 6a: flush in the stall cycle
        row(1, 0, 0, 0,  5, 1, 2, 0, 0,  0, 0, 0, 0, "t6a_load");
        row(1, 0, 5, 2, 12, 1, 1, 0, 1,  0, 1, 0, 0, "t6a_flush");
        idle(0, 0, 0, "t6a_bubble");
        idle(0, 0, 0, "t6a_drain");
        idle(0, 0, 0, "t6a_drain2");

        // 6b: hold for three cycles freezes EX state
        row(1, 0, 0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 0, "t6b_prod");
        row(1, 3, 0, 1, 14, 1, 1, 0, 0,  0, 1, 0, 0, "t6b_cons");
        row(0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 1, 1, 0, "t6b_hold1");
        row(0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 1, 1, 0, "t6b_hold2");
        row(0, 0, 0, 0,  0, 0, 1, 1, 0,  0, 1, 1, 0, "t6b_hold3");
        idle(1, 1, 0, "t6b_release");
        idle(0, 0, 0, "t6b_drain");
        idle(0, 0, 0, "t6b_drain2");

        // 6c: reset pulse in the middle of a load-use stall
        row(1, 0, 0, 0,  5, 1, 2, 0, 0,  0, 0, 0, 0, "t6c_load");
        row(1, 0, 5, 2, 12, 1, 1, 0, 0,  1, 1, 0, 0, "t6c_stall");
        #4 rst_n = 1'b0;
        row(1, 0, 5, 2, 12, 1, 1, 0, 0,  0, 0, 0, 0, "t6c_in_rst");
        #3 rst_n = 1'b1;
        idle(1, 0, 0, "t6c_after_rst");
        idle(0, 0, 0, "t6c_drain");

        repeat (2) @(negedge clk);
        #5;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
